flux_fifo: RTL and testbench
============================

FLUX_FIFO -- requirements
Module: flux_fifo

Interface
REQ-001 SHALL have parameter FLUX, default 2, number of independent data fluxes (legal range 2 to 16).
REQ-002 SHALL have parameter DEPTH, default 4, entries per flux (power of two, at least 2).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel width; TAG_WIDTH = clog2(FLUX); WIDTH = DATA_WIDTH + TAG_WIDTH.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 write  in  1  producer pushes din this cycle.
REQ-007 din  in  WIDTH  {tag, data}; tag in the upper TAG_WIDTH bits selects the target flux.
REQ-008 full  out  FLUX  bit i high when flux i holds DEPTH entries.
REQ-009 read  in  FLUX  consumer pops the head of flux i when bit i is high; one-hot or zero.
REQ-010 empty  out  FLUX  bit i high when flux i holds 0 entries.
REQ-011 dout  out  WIDTH  {flux index, head data} of the flux being read (see REQ-017).
REQ-012 err  out  1  sticky protocol-violation flag.

Function
REQ-013 SHALL keep per flux a circular buffer of DEPTH x DATA_WIDTH, a write pointer, a read pointer (each clog2(DEPTH) bits, wrapping DEPTH-1 to 0) and an occupancy count (clog2(DEPTH)+1 bits).
REQ-014 full and empty SHALL be decoded from registered counts only; they SHALL NOT depend combinationally on write or read.
REQ-015 Accepted write: write=1, tag t < FLUX and full[t]=0 -> data stored at wptr[t], wptr[t] advances, count[t]+1 at next edge.
REQ-016 Accepted read: read[i]=1 and empty[i]=0 -> rptr[i] advances, count[i]-1 at next edge.
REQ-017 dout SHALL be first-word-fall-through, combinational: if read has a bit set, index s = lowest set bit; otherwise s = lowest-index non-empty flux; dout = {s, mem[s][rptr[s]]}; if no bit set and all fluxes empty, dout = 0.
REQ-018 Simultaneous accepted write and read on the same flux SHALL leave count unchanged and advance both pointers; write and read on different fluxes SHALL act independently.
REQ-019 Write to a full flux, or with tag >= FLUX, SHALL be dropped with no state change; pointers and count SHALL be unchanged even if the same flux is read that cycle.
REQ-020 Read of an empty flux SHALL be ignored, including when the same flux is written that cycle; write-through to dout SHALL NOT occur.
REQ-021 Multi-hot read SHALL honour only the lowest set bit; the other bits SHALL be ignored.
REQ-022 err SHALL set at the edge following any REQ-019, REQ-020 or REQ-021 event and SHALL hold until reset.
REQ-023 The block SHALL have zero-cycle read latency and one-cycle write-to-visible latency: data written at edge k appears on dout and clears empty after edge k.
REQ-024 Per-flux order SHALL be strictly FIFO; fluxes SHALL NOT block one another.

Reset
REQ-025 While rst=1, regardless of clk: all pointers and counts 0, empty all ones, full all zeros, err 0, dout 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-027 The first accepted write SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-028 FLUX=2, DEPTH=4: after reset, write {0,0x11},{0,0x22} -> empty=2'b10; read[0]=1 -> dout={0,0x11}; next cycle dout={0,0x22}; then empty=2'b11.
REQ-029 Fill flux 1 with 0xA0..0xA3 -> full=2'b10; write {1,0xA4} -> dropped, err=1; drain -> 0xA0..0xA3 in order.
REQ-030 Six write/read pairs on flux 0 to force pointer wrap -> data returned in order, count never exceeds 1, err stays 0.
REQ-031 Flux 0 full, same cycle write {0,0x55} and read[0]=1 -> read accepted, write dropped, count 3, err=1.
REQ-032 Both fluxes hold data, read=2'b11 -> only flux 0 pops, dout tag 0, err=1; assert rst asynchronously between edges -> empty=2'b11, full=0, err=0 immediately.

Source files
------------

// File: rtl/flux_fifo.sv
// Multi-flux FIFO: FLUX independent circular buffers sharing one write port.
// The write tag selects the target flux; reads are one-hot per flux and the
// selected head is presented first-word-fall-through on dout.
module flux_fifo #(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned TAG_WIDTH = $clog2(FLUX),
  localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic [FLUX-1:0]  full,
  input  logic [FLUX-1:0]  read,
  output logic [FLUX-1:0]  empty,
  output logic [WIDTH-1:0] dout,
  output logic             err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem  [FLUX][DEPTH];
  logic [PTR_W-1:0]      r_wptr [FLUX];
  logic [PTR_W-1:0]      r_rptr [FLUX];
  logic [CNT_W-1:0]      r_cnt  [FLUX];
  logic                  r_err;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic [FLUX-1:0]       w_full;
  logic [FLUX-1:0]       w_empty;
  logic [FLUX-1:0]       w_wr_en;
  logic [FLUX-1:0]       w_rd_low;
  logic [FLUX-1:0]       w_rd_en;
  logic                  w_wr_bad;
  logic                  w_rd_bad;
  logic                  w_multi;
  logic [FLUX-1:0]       w_cand;
  logic [TAG_WIDTH-1:0]  w_sel;

  assign w_tag  = din[WIDTH-1 -: TAG_WIDTH];
  assign w_data = din[DATA_WIDTH-1:0];

  // Status flags decoded purely from the registered occupancy counts
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int i = 0; i < int'(FLUX); i++) begin
      w_full[i]  = (r_cnt[i] == CNT_W'(DEPTH));
      w_empty[i] = (r_cnt[i] == '0);
    end
  end

  assign full  = w_full;
  assign empty = w_empty;

  // Write steering: a tag beyond FLUX-1 matches no flux and is dropped
  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < int'(FLUX); i++) begin
      w_wr_en[i] = write && (w_tag == TAG_WIDTH'(i)) && !w_full[i];
    end
  end

  // Only the lowest requested read is honoured; empty targets are ignored
  assign w_rd_low = read & (~read + FLUX'(1));
  assign w_rd_en  = w_rd_low & ~w_empty;
  assign w_rd_bad = |(w_rd_low & w_empty);
  assign w_multi  = |(read & (read - FLUX'(1)));
  assign w_wr_bad = write && !(|w_wr_en);

  // Output flux select: requested read wins, otherwise lowest non-empty flux
  always_comb begin
    w_cand = (|read) ? read : ~w_empty;
    w_sel  = '0;
    for (int i = int'(FLUX) - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel = TAG_WIDTH'(i);
    end
  end

  assign dout = (rst || (w_cand == '0)) ? '0 : {w_sel, r_mem[w_sel][r_rptr[w_sel]]};
  assign err  = r_err;

  // Storage array; contents survive reset since counts gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(FLUX); i++) begin
      if (w_wr_en[i]) r_mem[i][r_wptr[i]] <= w_data;
    end
  end

  // Pointer, occupancy and sticky error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FLUX); i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < int'(FLUX); i++) begin
        if (w_wr_en[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_rd_en[i]) r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        if (w_wr_en[i] && !w_rd_en[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (!w_wr_en[i] && w_rd_en[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
      if (w_wr_bad || w_rd_bad || w_multi) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flux_fifo.sv
// Bench for flux_fifo (FLUX=2, DEPTH=4, DATA_WIDTH=8): directed scenarios
// followed by random traffic, scored against per-flux queues.
module tb_flux_fifo;

  localparam int unsigned FLUX  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned W     = 9;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            write;
  logic [W-1:0]    din;
  logic [FLUX-1:0] full;
  logic [FLUX-1:0] read;
  logic [FLUX-1:0] empty;
  logic [W-1:0]    dout;
  logic            err;

  int checks;
  int errors;

  logic [DW-1:0] mq [2][$];
  logic          merr;
  exp_t          sq [$];

  flux_fifo #(.FLUX(FLUX), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .write (write),
    .din   (din),
    .full  (full),
    .read  (read),
    .empty (empty),
    .dout  (dout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: compare dout whenever an expectation is pending
  always @(negedge clk) begin
    exp_t e;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      if (e.v) begin
        checks++;
        if (dout !== e.d) begin
          errors++;
          $display("FAIL dout t=%0t got %h want %h", $time, dout, e.d);
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic check_state();
    logic [FLUX-1:0] ef;
    logic [FLUX-1:0] ee;
    for (int i = 0; i < 2; i++) begin
      ef[i] = (mq[i].size() == DEPTH);
      ee[i] = (mq[i].size() == 0);
    end
    cmp("full",  W'(full),  W'(ef));
    cmp("empty", W'(empty), W'(ee));
    cmp("err",   W'(err),   W'(merr));
  endtask

  // Expected FWFT output for the given read vector in the current model state
  function automatic exp_t exp_dout(input logic [FLUX-1:0] r);
    exp_t e;
    int s;
    e.v = 1'b1;
    e.d = '0;
    if (r != 0) begin
      s = r[0] ? 0 : 1;
      if (mq[s].size() > 0) e.d = {1'(s), mq[s][0]};
      else e.v = 1'b0;
    end else if (mq[0].size() > 0) begin
      e.d = {1'b0, mq[0][0]};
    end else if (mq[1].size() > 0) begin
      e.d = {1'b1, mq[1][0]};
    end
    return e;
  endfunction

  task automatic model_step(input logic w, input logic [W-1:0] d, input logic [FLUX-1:0] r);
    int  lo;
    int  t;
    bit  rd_ok;
    bit  wr_ok;
    lo    = r[0] ? 0 : (r[1] ? 1 : -1);
    t     = int'(d[W-1]);
    rd_ok = (lo >= 0) && (mq[lo].size() > 0);
    wr_ok = w && (mq[t].size() < DEPTH);
    if (w && !wr_ok) merr = 1'b1;
    if (lo >= 0 && !rd_ok) merr = 1'b1;
    if (r == 2'b11) merr = 1'b1;
    if (rd_ok) void'(mq[lo].pop_front());
    if (wr_ok) mq[t].push_back(d[DW-1:0]);
  endtask

  // One clock of stimulus: entered and left at posedge+1
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic [FLUX-1:0] r);
    check_state();
    sq.push_back(exp_dout(r));
    write = w;
    din   = d;
    read  = r;
    @(posedge clk);
    #1;
    model_step(w, d, r);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    write = 1'b0;
    read  = '0;
    din   = '0;
    #1 rst = 1'b1;
    #1;
    cmp("rst_empty", W'(empty), W'(2'b11));
    cmp("rst_full",  W'(full),  W'(2'b00));
    cmp("rst_err",   W'(err),   W'(1'b0));
    cmp("rst_dout",  dout,      W'(0));
    mq[0].delete();
    mq[1].delete();
    merr = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [FLUX-1:0] r;
    int              k;
    checks = 0;
    errors = 0;
    merr   = 1'b0;
    rst    = 1'b1;
    write  = 1'b0;
    din    = '0;
    read   = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("init_empty", W'(empty), W'(2'b11));
    cmp("init_full",  W'(full),  W'(2'b00));
    cmp("init_dout",  dout,      W'(0));
    rst = 1'b0;

    // Two writes then drain on flux 0
    cycle(1'b1, 9'h011, 2'b00);
    cycle(1'b1, 9'h022, 2'b00);
    cycle(1'b0, 9'h000, 2'b01);
    cycle(1'b0, 9'h000, 2'b01);
    cycle(1'b0, 9'h000, 2'b00);

    // Fill flux 1, overflow write, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, {1'b1, 8'(8'hA0 + i)}, 2'b00);
    cycle(1'b1, 9'h1A4, 2'b00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 2'b10);
    cycle(1'b0, 9'h000, 2'b00);
    async_reset();

    // Pointer wrap on flux 0 with single-entry occupancy
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, {1'b0, 8'(8'h30 + i)}, 2'b00);
      cycle(1'b0, 9'h000, 2'b01);
    end
    cycle(1'b0, 9'h000, 2'b00);

    // Full flux 0 with simultaneous write and read
    for (int i = 0; i < 4; i++) cycle(1'b1, {1'b0, 8'(8'h40 + i)}, 2'b00);
    cycle(1'b1, 9'h055, 2'b01);
    for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 2'b01);
    cycle(1'b0, 9'h000, 2'b00);
    async_reset();

    // Multi-hot read with both fluxes populated, then async reset
    cycle(1'b1, 9'h061, 2'b00);
    cycle(1'b1, 9'h162, 2'b00);
    cycle(1'b0, 9'h000, 2'b11);
    cycle(1'b0, 9'h000, 2'b00);
    async_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4)      r = 2'b00;
      else if (k < 7) r = 2'b01;
      else if (k < 9) r = 2'b10;
      else            r = 2'b11;
      if ($urandom_range(0, 499) == 0) async_reset();
      cycle(($urandom_range(0, 9) < 6), W'($urandom), r);
    end
    check_state();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
